alu_op_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 54 +++++
 rtl/alu_cond_eval.sv | 25 ++
 rtl/alu_op_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU operation sequencer: states, flag indices,
// condition codes, shift/rotate FunSel range and instruction field positions.
package alu_seq_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SRC  = 3'd1;
  localparam logic [2:0] ST_EXEC = 3'd2;
  localparam logic [2:0] ST_EVAL = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_Z  = 3'b001;
  localparam logic [2:0] COND_NZ = 3'b010;
  localparam logic [2:0] COND_C  = 3'b011;
  localparam logic [2:0] COND_NC = 3'b100;
  localparam logic [2:0] COND_N  = 3'b101;
  localparam logic [2:0] COND_O  = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;

  localparam logic [3:0] FUN_SHIFT_LO = 4'b1011;
  localparam logic [3:0] FUN_ROT_LO   = 4'b1110;

  localparam int IR_CLASS   = 15;
  localparam int IR_FUN_HI  = 14;
  localparam int IR_FUN_LO  = 10;
  localparam int IR_S       = 9;
  localparam int IR_DST_HI  = 8;
  localparam int IR_DST_LO  = 6;
  localparam int IR_SRCA_HI = 5;
  localparam int IR_SRCA_LO = 3;
  localparam int IR_SRCB_HI = 2;
  localparam int IR_SRCB_LO = 0;
  localparam int IR_RSV_HI  = 14;
  localparam int IR_RSV_LO  = 13;
  localparam int IR_COND_HI = 12;
  localparam int IR_COND_LO = 10;
  localparam int IR_OFF_HI  = 9;

  function automatic logic is_shift(input logic [4:0] fun);
    return fun[3:0] >= FUN_SHIFT_LO;
  endfunction

  function automatic logic is_rotate(input logic [4:0] fun);
    return fun[3:0] >= FUN_ROT_LO;
  endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational branch-condition evaluation against the ALU flag vector.
import alu_seq_pkg::*;

module alu_cond_eval (
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_Z:  taken = flags[FLAG_Z];
      COND_NZ: taken = !flags[FLAG_Z];
      COND_C:  taken = flags[FLAG_C];
      COND_NC: taken = !flags[FLAG_C];
      COND_N:  taken = flags[FLAG_N];
      COND_O:  taken = flags[FLAG_O];
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer driving ALU/register-file controls from 16-bit
// instructions; every output is registered from next-state values.
import alu_seq_pkg::*;

module alu_op_sequencer #(
  parameter int MAX_REPEAT = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InstrValid,
  input  logic [15:0] Instr,
  output logic        InstrReady,
  input  logic [3:0]  FlagsIn,
  output logic [4:0]  FunSel,
  output logic        WF,
  output logic [2:0]  SrcASel,
  output logic [2:0]  SrcBSel,
  output logic [2:0]  DstSel,
  output logic        RegWE,
  output logic        PCLoad,
  output logic [15:0] PCOffset,
  output logic        Done,
  output logic        IllegalOp
);

  localparam logic [2:0] MAX_LAST = 3'(MAX_REPEAT - 1);

  state_t      state_reg, state_next;
  logic [15:0] ir_reg, ir_next;
  logic [2:0]  iter_reg, iter_next;
  logic [2:0]  last_iter;
  logic        accept, taken, reserved;
  logic [4:0]  fun_next;

  logic        ready_next, wf_next, regwe_next, pcload_next, done_next, illegal_next;
  logic [4:0]  funsel_next;
  logic [2:0]  srca_next, srcb_next, dst_next;
  logic [15:0] pcoffset_next;

  alu_cond_eval u_cond (
    .cond  (ir_reg[IR_COND_HI:IR_COND_LO]),
    .flags (FlagsIn),
    .taken (taken)
  );

  assign accept    = InstrValid && InstrReady;
  assign reserved  = ir_reg[IR_RSV_HI:IR_RSV_LO] != 2'b00;
  assign last_iter = (ir_reg[IR_SRCB_HI:IR_SRCB_LO] > MAX_LAST) ? MAX_LAST
                                                                : ir_reg[IR_SRCB_HI:IR_SRCB_LO];

  always_comb begin
    ir_next    = accept ? Instr : ir_reg;
    state_next = state_reg;
    iter_next  = iter_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (accept) state_next = Instr[IR_CLASS] ? ST_EVAL : ST_SRC;
        else        state_next = ST_IDLE;
      end
      ST_SRC: begin
        state_next = ST_EXEC;
        iter_next  = 3'd0;
      end
      ST_EXEC: begin
        // Shift-class ops loop in EXEC, one single-bit step per cycle.
        if (is_shift(ir_reg[IR_FUN_HI:IR_FUN_LO]) && iter_reg != last_iter)
          iter_next = iter_reg + 3'd1;
        else
          state_next = ST_DONE;
      end
      ST_EVAL: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    fun_next      = ir_next[IR_FUN_HI:IR_FUN_LO];
    ready_next    = (state_next == ST_IDLE) || (state_next == ST_DONE);
    done_next     = state_next == ST_DONE;
    funsel_next   = 5'd0;
    wf_next       = 1'b0;
    regwe_next    = 1'b0;
    srca_next     = 3'd0;
    srcb_next     = 3'd0;
    dst_next      = 3'd0;
    if (state_next == ST_SRC || state_next == ST_EXEC) begin
      funsel_next = fun_next;
      srca_next   = ir_next[IR_SRCA_HI:IR_SRCA_LO];
      srcb_next   = is_shift(fun_next) ? 3'd0 : ir_next[IR_SRCB_HI:IR_SRCB_LO];
    end
    if (state_next == ST_EXEC) begin
      regwe_next = 1'b1;
      dst_next   = ir_next[IR_DST_HI:IR_DST_LO];
      // Rotates always write flags so the carry chains between iterations.
      wf_next    = ir_next[IR_S] || is_rotate(fun_next);
      if (iter_next != 3'd0) srca_next = ir_next[IR_DST_HI:IR_DST_LO];
    end
    pcload_next   = (state_reg == ST_EVAL) && !reserved && taken;
    illegal_next  = (state_reg == ST_EVAL) && reserved;
    pcoffset_next = (state_reg == ST_EVAL) ? {{6{ir_reg[IR_OFF_HI]}}, ir_reg[IR_OFF_HI:0]}
                                           : PCOffset;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg  <= ST_IDLE;
      ir_reg     <= 16'd0;
      iter_reg   <= 3'd0;
      InstrReady <= 1'b0;
      FunSel     <= 5'd0;
      WF         <= 1'b0;
      SrcASel    <= 3'd0;
      SrcBSel    <= 3'd0;
      DstSel     <= 3'd0;
      RegWE      <= 1'b0;
      PCLoad     <= 1'b0;
      PCOffset   <= 16'd0;
      Done       <= 1'b0;
      IllegalOp  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ir_reg     <= ir_next;
      iter_reg   <= iter_next;
      InstrReady <= ready_next;
      FunSel     <= funsel_next;
      WF         <= wf_next;
      SrcASel    <= srca_next;
      SrcBSel    <= srcb_next;
      DstSel     <= dst_next;
      RegWE      <= regwe_next;
      PCLoad     <= pcload_next;
      PCOffset   <= pcoffset_next;
      Done       <= done_next;
      IllegalOp  <= illegal_next;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed-vector bench for alu_op_sequencer; expected values hand-computed
// from the instruction encodings.
module tb_alu_op_sequencer;

  logic        Clock;
  logic        Reset;
  logic        InstrValid;
  logic [15:0] Instr;
  logic        InstrReady;
  logic [3:0]  FlagsIn;
  logic [4:0]  FunSel;
  logic        WF;
  logic [2:0]  SrcASel, SrcBSel, DstSel;
  logic        RegWE, PCLoad, Done, IllegalOp;
  logic [15:0] PCOffset;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer #(.MAX_REPEAT(8)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .InstrReady (InstrReady),
    .FlagsIn    (FlagsIn),
    .FunSel     (FunSel),
    .WF         (WF),
    .SrcASel    (SrcASel),
    .SrcBSel    (SrcBSel),
    .DstSel     (DstSel),
    .RegWE      (RegWE),
    .PCLoad     (PCLoad),
    .PCOffset   (PCOffset),
    .Done       (Done),
    .IllegalOp  (IllegalOp)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] all_outs();
    return {4'd0, InstrReady, FunSel, WF, SrcASel, SrcBSel, DstSel,
            RegWE, PCLoad, PCOffset, Done, IllegalOp};
  endfunction

  // Present a word and hold it until the sequencer takes it; returns the
  // number of negedges spent waiting for InstrReady.
  task automatic send(input logic [15:0] word, output int waits);
    waits = 0;
    @(negedge Clock);
    Instr      = word;
    InstrValid = 1'b1;
    while (!InstrReady && waits < 20) begin
      @(negedge Clock);
      waits++;
    end
    check("ready_timeout", {39'd0, InstrReady}, 40'd1);
    @(posedge Clock);
    #1 InstrValid = 1'b0;
    $display("txn instr=0x%04h accepted after %0d wait cycles", word, waits);
  endtask

  task automatic run_branch(input string name, input logic [15:0] word, input logic [3:0] flags,
                            input logic exp_pcload, input logic exp_ill, input logic [15:0] exp_off);
    int w;
    FlagsIn = flags;
    send(word, w);
    @(negedge Clock);
    check({name, "_eval_done"},  {39'd0, Done}, 40'd0);
    check({name, "_eval_ready"}, {39'd0, InstrReady}, 40'd0);
    @(negedge Clock);
    check({name, "_pcload"}, {39'd0, PCLoad}, {39'd0, exp_pcload});
    check({name, "_illegal"}, {39'd0, IllegalOp}, {39'd0, exp_ill});
    check({name, "_done"}, {39'd0, Done}, 40'd1);
    check({name, "_regwe"}, {39'd0, RegWE}, 40'd0);
    if (!exp_ill) check({name, "_offset"}, {24'd0, PCOffset}, {24'd0, exp_off});
    @(negedge Clock);
    check({name, "_done_pulse"}, {39'd0, Done}, 40'd0);
  endtask

  initial begin
    int w;
    logic saw_we;
    Reset      = 1'b0;
    InstrValid = 1'b0;
    Instr      = 16'd0;
    FlagsIn    = 4'd0;

    repeat (3) @(negedge Clock);
    check("reset_outs", all_outs(), 40'd0);
    Reset = 1'b1;
    #1 check("ready_at_release", {39'd0, InstrReady}, 40'd0);
    @(negedge Clock);
    check("ready_first_edge", {39'd0, InstrReady}, 40'd1);

    // ADD16 with flags, 0x1253
    send(16'h1253, w);
    @(negedge Clock);
    check("add_src_a",   {37'd0, SrcASel}, 40'd2);
    check("add_src_b",   {37'd0, SrcBSel}, 40'd3);
    check("add_src_fun", {35'd0, FunSel}, 40'h04);
    check("add_src_we",  {39'd0, RegWE}, 40'd0);
    check("add_src_wf",  {39'd0, WF}, 40'd0);
    @(negedge Clock);
    check("add_exec_we",  {39'd0, RegWE}, 40'd1);
    check("add_exec_dst", {37'd0, DstSel}, 40'd1);
    check("add_exec_wf",  {39'd0, WF}, 40'd1);
    check("add_exec_fun", {35'd0, FunSel}, 40'h04);
    @(negedge Clock);
    check("add_done",       {39'd0, Done}, 40'd1);
    check("add_done_we",    {39'd0, RegWE}, 40'd0);
    check("add_done_fun",   {35'd0, FunSel}, 40'd0);
    check("add_done_ready", {39'd0, InstrReady}, 40'd1);
    @(negedge Clock);
    check("add_idle_done", {39'd0, Done}, 40'd0);

    // LSL32 count 4, Dst=SrcA=4, 0x6D23
    send(16'h6D23, w);
    @(negedge Clock);
    check("lsl_src_a", {37'd0, SrcASel}, 40'd4);
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clock);
      check("lsl_exec_fun", {35'd0, FunSel}, 40'h1B);
      check("lsl_exec_wf",  {39'd0, WF}, 40'd0);
      check("lsl_exec_a",   {37'd0, SrcASel}, 40'd4);
      check("lsl_exec_we",  {39'd0, RegWE}, 40'd1);
      check("lsl_exec_dst", {37'd0, DstSel}, 40'd4);
      check("lsl_exec_done", {39'd0, Done}, 40'd0);
    end
    @(negedge Clock);
    check("lsl_done",    {39'd0, Done}, 40'd1);
    check("lsl_done_we", {39'd0, RegWE}, 40'd0);

    // LSL32 count 3, Dst=2, SrcA=5: later iterations read back Dst, 0x6CAA
    send(16'h6CAA, w);
    @(negedge Clock);
    @(negedge Clock);
    check("lsl3_it1_a", {37'd0, SrcASel}, 40'd5);
    @(negedge Clock);
    check("lsl3_it2_a", {37'd0, SrcASel}, 40'd2);
    @(negedge Clock);
    check("lsl3_it3_a",  {37'd0, SrcASel}, 40'd2);
    check("lsl3_it3_we", {39'd0, RegWE}, 40'd1);
    @(negedge Clock);
    check("lsl3_done", {39'd0, Done}, 40'd1);

    // CSR16 count 1 with S=0: rotate still writes flags, 0x3C00
    send(16'h3C00, w);
    @(negedge Clock);
    @(negedge Clock);
    check("csr_wf",  {39'd0, WF}, 40'd1);
    check("csr_we",  {39'd0, RegWE}, 40'd1);
    check("csr_fun", {35'd0, FunSel}, 40'h0F);
    @(negedge Clock);
    check("csr_done", {39'd0, Done}, 40'd1);

    run_branch("beq_taken",  16'h87FC, 4'b1000, 1'b1, 1'b0, 16'hFFFC);
    run_branch("beq_not",    16'h87FC, 4'b0000, 1'b0, 1'b0, 16'hFFFC);
    run_branch("bne_taken",  16'h8BFC, 4'b0000, 1'b1, 1'b0, 16'hFFFC);
    run_branch("never",      16'h9C05, 4'b1111, 1'b0, 1'b0, 16'h0005);
    run_branch("reserved",   16'hA000, 4'b1000, 1'b0, 1'b1, 16'h0000);

    // Back-to-back: branch accepted in the DONE cycle of an ADD
    FlagsIn = 4'b0000;
    send(16'h1253, w);
    send(16'h8000, w);
    check("b2b_waits", 40'(w), 40'd2);
    @(negedge Clock);
    check("b2b_eval_done", {39'd0, Done}, 40'd0);
    @(negedge Clock);
    check("b2b_pcload", {39'd0, PCLoad}, 40'd1);
    check("b2b_done",   {39'd0, Done}, 40'd1);

    // Reset during the second EXEC iteration of 0x6D23
    send(16'h6D23, w);
    @(negedge Clock);
    @(negedge Clock);
    @(negedge Clock);
    check("rst_pre_we", {39'd0, RegWE}, 40'd1);
    Reset = 1'b0;
    #1 check("rst_mid_outs", all_outs(), 40'd0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check("rst_ready_first_edge", {39'd0, InstrReady}, 40'd1);
    saw_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clock);
      saw_we = saw_we | RegWE | WF;
    end
    check("rst_no_write", {39'd0, saw_we}, 40'd0);
    $display("txn reset mid-exec recovered");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
